// File: rtl/alt_dfe_pkg.sv
// DFE register map constants, FSM state type and field lookup helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alt_dfe_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MAP     = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        WR_REQ  = 3'd4,
        WR_WAIT = 3'd5,
        DONE    = 3'd6
    } dfe_state_t;

    // Low nibble of every physical DFE register address.
    localparam logic [3:0]  DFE_REG_OFS   = 4'h6;
    // Remap value meaning "no physical channel behind this logical one".
    localparam logic [11:0] INVALID_REMAP = 12'hfff;

    localparam logic [15:0] MASK0 = 16'h000F;  // tap1
    localparam logic [15:0] MASK1 = 16'h0070;  // tap2
    localparam logic [15:0] MASK2 = 16'h0380;  // tap3

    // Field mask inside the DFE register for a word select.
    function automatic logic [15:0] dfe_mask(input logic [1:0] w);
        case (w)
            2'd0:    return MASK0;
            2'd1:    return MASK1;
            2'd2:    return MASK2;
            default: return 16'h0000;
        endcase
    endfunction

    // Bit position of the field LSB for a word select.
    function automatic logic [3:0] dfe_shift(input logic [1:0] w);
        case (w)
            2'd0:    return 4'd0;
            2'd1:    return 4'd4;
            2'd2:    return 4'd7;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/alt_dfe_ir_field_merge.sv
// Extracts a DFE field from a register word and merges a new field value into it.
// Latency: combinational.
// Backpressure: none.
//   word_sel    : DFE word select (0 tap1, 1 tap2, 2 tap3)
//   rd_word     : register word as read from DPRIO
//   wr_field    : right-justified new field value (excess bits dropped)
//   field_val   : right-justified field taken from rd_word
//   merged_word : rd_word with the field replaced by wr_field
module alt_dfe_ir_field_merge
    import alt_dfe_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [1:0]        word_sel,
    input  logic [DATA_W-1:0] rd_word,
    input  logic [DATA_W-1:0] wr_field,
    output logic [DATA_W-1:0] field_val,
    output logic [DATA_W-1:0] merged_word
);

    logic [DATA_W-1:0] mask;
    logic [3:0]        sh;

    always_comb begin
        mask        = DATA_W'(dfe_mask(word_sel));
        sh          = dfe_shift(word_sel);
        field_val   = (rd_word & mask) >> sh;
        // Masking after the shift discards writedata bits wider than the field.
        merged_word = (rd_word & ~mask) | ((wr_field << sh) & mask);
    end

endmodule

// File: rtl/alt_dfe_ir_master.sv
// DFE register access engine: one read or read-modify-write on DPRIO per trigger.
// Latency: trigger to done 5 cycles (read), 7 cycles (write), 2 cycles (bad address).
// Backpressure: strobes wait while i_dprio_busy; read waits for i_dprio_datavalid.
//   Inputs : i_avmm_clk, i_reset (async, active high), i_ir_m* request from slave,
//            i_remap_address (physical channel, 12'hfff invalid), i_dprio_* port.
//   Outputs: o_ir_mdone / o_ir_mreaddata / o_ir_merror to slave, o_dprio_* strobes.
//   Build option: ALT_DFE_IR_MASTER_TIMEOUT_EN adds a watchdog of TIMEOUT_CYCLES.
module alt_dfe_ir_master
    import alt_dfe_pkg::*;
#(
    parameter int IREG_CHADDR_WIDTH = 16,
    parameter int IREG_WDADDR_WIDTH = 16,
    parameter int IREG_DATA_WIDTH   = 16,
    parameter int DPRIO_ADDR_WIDTH  = 16,
    parameter int TIMEOUT_CYCLES    = 1024
) (
    input  logic                         i_avmm_clk,
    input  logic                         i_reset,
    input  logic                         i_ir_mtrigger,
    input  logic                         i_ir_mrwn,
    input  logic [IREG_CHADDR_WIDTH-1:0] i_ir_mchaddress,
    input  logic [IREG_WDADDR_WIDTH-1:0] i_ir_mwdaddress,
    input  logic [IREG_DATA_WIDTH-1:0]   i_ir_mwritedata,
    input  logic [11:0]                  i_remap_address,
    output logic                         o_ir_mdone,
    output logic [IREG_DATA_WIDTH-1:0]   o_ir_mreaddata,
    output logic                         o_ir_merror,
    output logic [DPRIO_ADDR_WIDTH-1:0]  o_dprio_addr,
    output logic [IREG_DATA_WIDTH-1:0]   o_dprio_wdata,
    output logic                         o_dprio_rden,
    output logic                         o_dprio_wren,
    input  logic                         i_dprio_busy,
    input  logic [IREG_DATA_WIDTH-1:0]   i_dprio_rdata,
    input  logic                         i_dprio_datavalid
);

    dfe_state_t state_q, state_d;

    logic                         rwn_q;
    logic [IREG_CHADDR_WIDTH-1:0] chaddr_q;
    logic [IREG_WDADDR_WIDTH-1:0] wdaddr_q;
    logic [IREG_DATA_WIDTH-1:0]   wfield_q;
    logic [IREG_DATA_WIDTH-1:0]   rd_word_q;
    logic                         err_q;
    logic                         rden_q, wren_q;
    logic [DPRIO_ADDR_WIDTH-1:0]  addr_q;
    logic [IREG_DATA_WIDTH-1:0]   wdata_q;
    logic [IREG_DATA_WIDTH-1:0]   readdata_q;

    // Per-state actions decoded by the output process.
    logic accept, map_load, rd_fire, rd_capture, wr_fire;
    logic addr_bad;
    logic timeout;

    // The channel is resolved upstream into i_remap_address; the latched
    // logical channel is kept only for debug visibility.
    logic unused_chaddr;
    assign unused_chaddr = ^chaddr_q;

    assign addr_bad = (i_remap_address == INVALID_REMAP) ||
                      (wdaddr_q > IREG_WDADDR_WIDTH'(2));

`ifdef ALT_DFE_IR_MASTER_TIMEOUT_EN
    logic [15:0] cnt_q;
    logic        waiting;

    assign waiting = (state_q == RD_REQ) || (state_q == RD_WAIT) ||
                     (state_q == WR_REQ) || (state_q == WR_WAIT);
    assign timeout = waiting && (cnt_q == 16'(TIMEOUT_CYCLES - 1));

    // Counts cycles spent in the current waiting state.
    always_ff @(posedge i_avmm_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else if (state_d != state_q) begin
            cnt_q <= '0;
        end else if (waiting) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // Read data goes straight into the extractor in the capture cycle so the
    // read result is ready with no extra stage; writes merge the held word.
    logic [IREG_DATA_WIDTH-1:0] merge_rd_word;
    logic [IREG_DATA_WIDTH-1:0] field_val, merged_word;

    assign merge_rd_word = (state_q == RD_WAIT) ? i_dprio_rdata : rd_word_q;

    alt_dfe_ir_field_merge #(
        .DATA_W (IREG_DATA_WIDTH)
    ) u_field_merge (
        .word_sel    (wdaddr_q[1:0]),
        .rd_word     (merge_rd_word),
        .wr_field    (wfield_q),
        .field_val   (field_val),
        .merged_word (merged_word)
    );

    // State register.
    always_ff @(posedge i_avmm_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_ir_mtrigger)     state_d = MAP;
            MAP:     state_d = addr_bad ? DONE : RD_REQ;
            RD_REQ:  if (!i_dprio_busy)     state_d = RD_WAIT;
            RD_WAIT: if (i_dprio_datavalid) state_d = rwn_q ? DONE : WR_REQ;
            WR_REQ:  if (!i_dprio_busy)     state_d = WR_WAIT;
            // The first WR_WAIT cycle carries wren, so leaving at its end
            // gives the DPRIO port one cycle to raise busy.
            WR_WAIT: if (!i_dprio_busy)     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (timeout) begin
            state_d = DONE;
        end
    end

    // Output decode: which register updates happen this cycle.
    always_comb begin
        accept     = 1'b0;
        map_load   = 1'b0;
        rd_fire    = 1'b0;
        rd_capture = 1'b0;
        wr_fire    = 1'b0;
        case (state_q)
            IDLE:    accept     = i_ir_mtrigger;
            MAP:     map_load   = 1'b1;
            RD_REQ:  rd_fire    = !i_dprio_busy && !timeout;
            RD_WAIT: rd_capture = i_dprio_datavalid && !timeout;
            WR_REQ:  wr_fire    = !i_dprio_busy && !timeout;
            default: ;
        endcase
    end

    // Request latch, registered strobes and result registers.
    always_ff @(posedge i_avmm_clk or posedge i_reset) begin
        if (i_reset) begin
            rwn_q      <= 1'b0;
            chaddr_q   <= '0;
            wdaddr_q   <= '0;
            wfield_q   <= '0;
            rd_word_q  <= '0;
            err_q      <= 1'b0;
            rden_q     <= 1'b0;
            wren_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            readdata_q <= '0;
        end else begin
            rden_q <= rd_fire;
            wren_q <= wr_fire;
            if (accept) begin
                rwn_q    <= i_ir_mrwn;
                chaddr_q <= i_ir_mchaddress;
                wdaddr_q <= i_ir_mwdaddress;
                wfield_q <= i_ir_mwritedata;
                err_q    <= 1'b0;
            end
            if (map_load) begin
                if (addr_bad) begin
                    err_q <= 1'b1;
                end else begin
                    addr_q <= DPRIO_ADDR_WIDTH'({i_remap_address, DFE_REG_OFS});
                end
            end
            if (rd_capture) begin
                rd_word_q <= i_dprio_rdata;
                if (rwn_q) begin
                    readdata_q <= field_val;
                end
            end
            if (wr_fire) begin
                wdata_q <= merged_word;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign o_ir_mdone     = (state_q == DONE);
    assign o_ir_merror    = (state_q == DONE) && err_q;
    assign o_ir_mreaddata = readdata_q;
    assign o_dprio_addr   = addr_q;
    assign o_dprio_wdata  = wdata_q;
    assign o_dprio_rden   = rden_q;
    assign o_dprio_wren   = wren_q;

endmodule

// File: doc/alt_dfe_ir_master.md
Name: alt_dfe_ir_master

Overview:
- Master-side engine directly downstream of the DFE Avalon-MM slave register file.
- On each trigger pulse it performs one DFE register access on the transceiver DPRIO-style port:
  - read: a single read of the DFE field;
  - write: a read-modify-write of the field.
- It returns a single-cycle done pulse plus read data to the slave, which then clears its busy bit and captures the data.

Parameters:
- IREG_CHADDR_WIDTH, 16, logical channel address width from the slave.
- IREG_WDADDR_WIDTH, 16, word address width; only values 0..2 are legal.
- IREG_DATA_WIDTH, 16, data width of the slave side and the DPRIO side.
- DPRIO_ADDR_WIDTH, 16, physical DPRIO address width.
- TIMEOUT_CYCLES, 1024, watchdog limit (used only with the optional feature).

Ports:
- i_avmm_clk  in  1  sole clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_ir_mtrigger  in  1  one-cycle start pulse from the slave.
- i_ir_mrwn  in  1  1 = read, 0 = write.
- i_ir_mchaddress  in  IREG_CHADDR_WIDTH  logical channel.
- i_ir_mwdaddress  in  IREG_WDADDR_WIDTH  DFE word select (0 tap1, 1 tap2, 2 tap3).
- i_ir_mwritedata  in  IREG_DATA_WIDTH  right-justified field write value.
- i_remap_address  in  12  physical channel from address_pres_reg; 12'hfff = invalid.
- o_ir_mdone  out  1  one-cycle completion pulse.
- o_ir_mreaddata  out  IREG_DATA_WIDTH  right-justified field value.
- o_ir_merror  out  1  aborted access, valid with o_ir_mdone.
- o_dprio_addr  out  DPRIO_ADDR_WIDTH  physical register address.
- o_dprio_wdata  out  IREG_DATA_WIDTH  merged write word.
- o_dprio_rden  out  1  read strobe.
- o_dprio_wren  out  1  write strobe.
- i_dprio_busy  in  1  DPRIO port busy.
- i_dprio_rdata  in  IREG_DATA_WIDTH  DPRIO read data.
- i_dprio_datavalid  in  1  i_dprio_rdata valid this cycle.

Behaviour:
- **Reset values:** state=IDLE, all outputs 0. Reset asserted mid-operation aborts immediately: strobes drop and no done pulse is issued.
- **IDLE:**
  - On i_ir_mtrigger, latch rwn, chaddress, wdaddress and writedata, then go to MAP.
  - A trigger in any other state is ignored.
- **MAP:** waits one cycle for the remap to settle, then latches i_remap_address.
  - If i_remap_address = 12'hfff or wdaddress > 2: go to DONE with err=1.
  - Otherwise compute o_dprio_addr = {remap, DFE_REG_OFS} with the offset taken from the package, then go to RD_REQ.
- **RD_REQ:** while i_dprio_busy=0, drive o_dprio_rden=1 for exactly one cycle, then go to RD_WAIT. While busy=1, hold in RD_REQ with no strobe.
- **RD_WAIT:** on i_dprio_datavalid, capture rdata.
  - Read operation: o_ir_mreaddata = (rdata & MASK[w]) >> SHIFT[w], then go to DONE.
  - Write operation: go to WR_REQ.
- **WR_REQ:**
  - Merged word = (rdata & ~MASK[w]) | ((writedata << SHIFT[w]) & MASK[w]); writedata bits beyond the field width are discarded.
  - Drive o_dprio_wren for one cycle once busy=0, then go to WR_WAIT.
- **WR_WAIT:** when busy=0 and at least one cycle has passed since wren, go to DONE. o_ir_mreaddata is left unchanged on writes.
- **DONE:** o_ir_mdone=1 for one cycle and o_ir_merror=err, then go to IDLE.
- **Minimum latencies, trigger to done with busy never asserted and datavalid one cycle after rden:** read = 5 cycles, write = 7 cycles.
- **Signal stability:**
  - o_dprio_addr and o_dprio_wdata hold stable from the strobe until the next access.
  - rden and wren are never high together.
- **Simultaneous events:** a trigger arriving in the DONE cycle is ignored, because the slave is still busy in that cycle.

Optional Feature:
- Macro: ALT_DFE_IR_MASTER_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on every state change and increments while in RD_REQ, RD_WAIT, WR_REQ or WR_WAIT.
  - Reaching TIMEOUT_CYCLES-1 forces DONE with err=1, the strobes low and o_ir_mreaddata unchanged.
- Undefined:
  - No counter exists; the engine waits indefinitely.
  - o_ir_merror is asserted only for invalid addresses.

Decomposition:
- Package alt_dfe_pkg:
  - state enum (IDLE, MAP, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE);
  - DFE_REG_OFS (4'h6);
  - MASK[0..2] = 16'h000F, 16'h0070, 16'h0380;
  - SHIFT[0..2] = 0, 4, 7;
  - INVALID_REMAP = 12'hfff.
- Sub-module alt_dfe_ir_field_merge: combinational extract and merge of the field. It keeps the FSM free of bit arithmetic.

Test Plan:
- **Read, word 1, remap 12'h005:** DPRIO returns 16'h00D5 → rden address 16'h0056, o_ir_mreaddata = 16'h0005, merror = 0, done at cycle 5.
- **Write, word 2, data 16'h0003, rdata 16'hFFFF:** wren with wdata 16'hFDFF (bits [9:7] = 011), done pulse, merror = 0.
- **Invalid address:** remap = 12'hfff or wdaddress = 3 → no strobe, done at cycle 2 with merror = 1.
- **Busy stall:** i_dprio_busy held for 20 cycles before the read → rden is delayed until busy drops and fires exactly once; extra triggers during the operation are ignored.
- **Reset mid-operation:** i_reset asserted in RD_WAIT → outputs go to 0 asynchronously, no done pulse; the next trigger proceeds normally.
- **Timeout, macro defined, TIMEOUT_CYCLES = 16:** datavalid is never returned → done with merror = 1 exactly 16 cycles after entering RD_WAIT.
